fetch_unit: RTL

Instruction fetch stage for the RISC-V core. It owns the program counter and issues requests to instruction memory over a req/ack handshake. It latches the returned word into an instruction register and presents it with a valid flag to the decode/control path, which drives the main controller's `op` input. On consumption it selects the next PC from PC+4, the jal/branch target or the jalr target, so redirects computed downstream close the loop here.

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/next_pc_logic.sv | 43 ++++
 rtl/fetch_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V core:
//   - fetch_state_e : fetch-stage FSM states (FETCH, VALID, TRAP)
//   - NOP_INSTR     : canonical nop (addi x0, x0, 0) loaded into the IR on reset
//   - RESET_PC_DEFAULT : default reset program counter
//   - OPC_*         : major opcode constants decoded by the main controller
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_VALID = 2'd1,
        ST_TRAP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/next_pc_logic.sv
// -----------------------------------------------------------------------------
// next_pc_logic
// Purely combinational next-PC selection for the fetch stage. Kept separate so
// a later pipelined fetch can reuse it unchanged.
// Ports:
//   pc          in  XLEN : current PC
//   immExt      in  XLEN : sign-extended immediate (jal/branch offset)
//   aluResult   in  XLEN : jalr target rs1 + imm
//   jal, jalr, branchTaken in 1 : redirect controls
//   pcPlus4     out XLEN : pc + 4 (also the link value)
//   nextPc      out XLEN : selected target, bits [1:0] untouched
//   misaligned  out 1    : nextPc[1:0] != 0
// -----------------------------------------------------------------------------
module next_pc_logic #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] immExt,
    input  logic [XLEN-1:0] aluResult,
    input  logic            jal,
    input  logic            jalr,
    input  logic            branchTaken,
    output logic [XLEN-1:0] pcPlus4,
    output logic [XLEN-1:0] nextPc,
    output logic            misaligned
);

    assign pcPlus4 = pc + XLEN'(4);

    // jalr has priority over jal/branch; its target always has bit 0 cleared.
    always_comb begin
        if (jalr) begin
            nextPc = {aluResult[XLEN-1:1], 1'b0};
        end else if (jal || branchTaken) begin
            nextPc = pc + immExt;
        end else begin
            nextPc = pcPlus4;
        end
    end

    assign misaligned = |nextPc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the word in an instruction register and hands it downstream with a
// valid flag. On consume the next PC comes from next_pc_logic.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned target -> TRAP
// state, left only by reset). Without it, target bits [1:0] are cleared.
// Ports:
//   clk, rst (sync, active-low)
//   imemReq/imemAddr out, imemAck/imemData in : instruction memory handshake
//   instr/instrValid/pc/pcPlus4 out, instrReady in : downstream interface
//   jal, jalr, branchTaken, immExt, aluResult in : redirect controls/targets
//   instrCount out : instructions consumed;  trap out : misaligned-target trap
// -----------------------------------------------------------------------------
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemAck,
    input  logic [31:0]     imemData,
    output logic [31:0]     instr,
    output logic            instrValid,
    input  logic            instrReady,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcPlus4,
    input  logic            jal,
    input  logic            jalr,
    input  logic            branchTaken,
    input  logic [XLEN-1:0] immExt,
    input  logic [XLEN-1:0] aluResult,
    output logic [31:0]     instrCount,
    output logic            trap
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     count_q, count_d;

    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    next_pc_logic #(.XLEN(XLEN)) u_next_pc (
        .pc          (pc_q),
        .immExt      (immExt),
        .aluResult   (aluResult),
        .jal         (jal),
        .jalr        (jalr),
        .branchTaken (branchTaken),
        .pcPlus4     (pcPlus4),
        .nextPc      (next_pc),
        .misaligned  (misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        case (state_q)
            ST_FETCH: begin
                if (imemAck) begin
                    instr_d = imemData;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (instrReady) begin
                    count_d = count_q + 32'd1;
                    state_d = ST_FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
                    // Keep the offending target in pc for debug.
                    pc_d = next_pc;
                    if (misaligned) begin
                        state_d = ST_TRAP;
                    end
`else
                    pc_d = misaligned ? {next_pc[XLEN-1:2], 2'b00} : next_pc;
`endif
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Request/valid are gated by rst so a mid-request reset drops imemReq at once.
    assign imemReq    = rst && (state_q == ST_FETCH);
    assign instrValid = rst && (state_q == ST_VALID);
    assign imemAddr   = pc_q;
    assign pc         = pc_q;
    assign instr      = instr_q;
    assign instrCount = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap = (state_q == ST_TRAP);
`else
    assign trap = 1'b0;
`endif

endmodule
